// File: rtl/load_store_unit.sv
// load_store_unit
// MEM-stage load/store initiator between the execute/memory pipeline register
// and a word-addressed, registered-read data memory.
//
// Handshake: a request is taken on any rising edge where ls_valid=1 and
// ls_busy=0 (ls_busy is the inverse of ready). While ls_busy=1 the ls_*
// inputs are ignored. Results come back as one-cycle pulses: ld_valid (with
// ld_data) for loads, ls_err for rejected requests.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ls_valid/ls_write/ls_size/ls_unsigned/ls_addr/ls_wdata   request
//   ls_busy               request in flight, pipeline must hold
//   ld_valid, ld_data     load completion pulse and extended result
//   ls_err                rejected-request pulse
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata          memory side
//   dbg_state             current FSM state encoding
module load_store_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_1000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_valid,
  input  logic        ls_write,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_busy,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        ls_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_CAPT   = 3'd2,
    S_WRITE1 = 3'd3,
    S_WRITE2 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // 33-bit bounds so the upper limit cannot wrap.
  localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);

  state_t state, state_n;

  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [1:0]  req_lo;
  logic [15:0] req_wdata;

  logic        accept;
  logic        req_err;
  logic [31:0] merged;
  logic [31:0] extracted;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign accept    = ls_valid && ((state == S_IDLE) || (state == S_DONE));
  assign ls_busy   = (state != S_IDLE) && (state != S_DONE);
  assign mem_read  = (state == S_READ) || (state == S_CAPT);
  assign mem_write = (state == S_WRITE1) || (state == S_WRITE2);
  assign dbg_state = state;

  // Request checks are evaluated on the incoming request at the accepting edge.
  always_comb begin
    req_err = 1'b0;
    if (ls_size == 2'b11) req_err = 1'b1;
    if ((ls_size == SZ_HALF) && ls_addr[0]) req_err = 1'b1;
    if ((ls_size == SZ_WORD) && (ls_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (({1'b0, ls_addr} < ADDR_LO) || ({1'b0, ls_addr} >= ADDR_HI)) req_err = 1'b1;
  end

  // Little-endian lane selection on the word read back from memory.
  assign sel_byte = mem_rdata[{req_lo, 3'b000} +: 8];
  assign sel_half = mem_rdata[{req_lo[1], 4'b0000} +: 16];

  always_comb begin
    extracted = mem_rdata;
    case (req_size)
      SZ_BYTE: extracted = {{24{~req_unsigned & sel_byte[7]}}, sel_byte};
      SZ_HALF: extracted = {{16{~req_unsigned & sel_half[15]}}, sel_half};
      default: extracted = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    case (req_size)
      SZ_BYTE: merged[{req_lo, 3'b000} +: 8]     = req_wdata[7:0];
      SZ_HALF: merged[{req_lo[1], 4'b0000} +: 16] = req_wdata;
      default: merged = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (accept) begin
          if (req_err)                              state_n = S_DONE;
          else if (ls_write && (ls_size == SZ_WORD)) state_n = S_WRITE1;
          else                                      state_n = S_READ;
        end
      end
      S_READ:   state_n = S_CAPT;
      S_CAPT:   state_n = req_write ? S_WRITE1 : S_DONE;
      S_WRITE1: state_n = S_WRITE2;
      S_WRITE2: state_n = S_DONE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Request capture, memory address/data registers and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_write    <= 1'b0;
      req_size     <= 2'b00;
      req_unsigned <= 1'b0;
      req_lo       <= 2'b00;
      req_wdata    <= 16'h0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      ld_data      <= 32'h0;
      ld_valid     <= 1'b0;
      ls_err       <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      ls_err   <= 1'b0;
      if (accept) begin
        req_write    <= ls_write;
        req_size     <= ls_size;
        req_unsigned <= ls_unsigned;
        req_lo       <= ls_addr[1:0];
        req_wdata    <= ls_wdata[15:0];
        if (req_err) begin
          ls_err <= 1'b1;
        end else begin
          // Address only moves for accesses that really reach memory.
          mem_addr <= {ls_addr[31:2], 2'b00};
          if (ls_write && (ls_size == SZ_WORD)) mem_wdata <= ls_wdata;
        end
      end
      if (state == S_CAPT) begin
        if (req_write) begin
          mem_wdata <= merged;
        end else begin
          ld_data  <= extracted;
          ld_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [31:0] BASE = 32'h1000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ls_valid = 1'b0;
  logic        ls_write = 1'b0;
  logic [1:0]  ls_size = 2'b00;
  logic        ls_unsigned = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic [31:0] ls_wdata = 32'h0;
  logic        ls_busy, ld_valid, ls_err, mem_read, mem_write;
  logic [31:0] ld_data, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  // bit 32 set = expected error pulse, else expected load data
  logic [32:0] exp_q[$];

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ls_valid(ls_valid), .ls_write(ls_write), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_busy(ls_busy), .ld_valid(ld_valid), .ld_data(ld_data), .ls_err(ls_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [256];
  logic [31:0] moff;
  assign moff = mem_addr - BASE;

  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= mem[moff[9:2]];
    if (mem_write) mem[moff[9:2]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_wr = 1'b0;
  logic [31:0] prev_waddr = 32'h0;
  logic [31:0] prev_wdata = 32'h0;

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      if (mem_read || mem_write)
        check("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
      if (mem_write && prev_wr) begin
        check("wr_addr_stable", mem_addr, prev_waddr);
        check("wr_data_stable", mem_wdata, prev_wdata);
      end
      if (ld_valid || ls_err) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_resp: got ld_valid=%0b ls_err=%0b expected none", ld_valid, ls_err);
        end else begin
          e = exp_q.pop_front();
          check("resp_kind", {30'b0, ls_err, ld_valid}, {30'b0, e[32], ~e[32]});
          if (ld_valid && !e[32]) check("ld_data", ld_data, e[31:0]);
        end
      end
      prev_wr    = mem_write;
      prev_waddr = mem_addr;
      prev_wdata = mem_wdata;
    end else begin
      prev_wr = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; drives the request, lets it be accepted, then
  // follows it until ls_busy drops (the DONE cycle), checking memory traffic.
  // exp is the load result for loads, the memory write data for stores.
  task automatic req(input bit w, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit err, input logic [31:0] exp);
    int busy, rds, wrs, exp_busy, exp_rds, exp_wrs;
    bit done;
    exp_busy = err ? 0 : ((w && sz != 2'b10) ? 4 : 2);
    exp_rds  = (err || (w && sz == 2'b10)) ? 0 : 2;
    exp_wrs  = (err || !w) ? 0 : 2;
    if (err)     exp_q.push_back({1'b1, 32'h0});
    else if (!w) exp_q.push_back({1'b0, exp});
    ls_valid = 1'b1; ls_write = w; ls_size = sz; ls_unsigned = uns;
    ls_addr = a; ls_wdata = d;
    @(posedge clk);
    #1 ls_valid = 1'b0;
    busy = 0; rds = 0; wrs = 0; done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (mem_read) rds++;
      if (mem_write) begin
        wrs++;
        check("mem_wdata", mem_wdata, exp);
      end
      if (mem_read || mem_write) check("mem_addr", mem_addr, {a[31:2], 2'b00});
      if (ls_busy) busy++;
      else done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL busy_timeout: got busy for 16 cycles expected release at %0d", exp_busy);
    end
    check("busy_cycles", busy, exp_busy);
    check("read_cycles", rds, exp_rds);
    check("write_cycles", wrs, exp_wrs);
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'b0, ls_busy}, 32'h0);
    check({tag, "_ldv"},   {31'b0, ld_valid}, 32'h0);
    check({tag, "_err"},   {31'b0, ls_err}, 32'h0);
    check({tag, "_rd"},    {31'b0, mem_read}, 32'h0);
    check({tag, "_wr"},    {31'b0, mem_write}, 32'h0);
    check({tag, "_addr"},  mem_addr, 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check({tag, "_lddata"}, ld_data, 32'h0);
    check({tag, "_state"}, {29'b0, dbg_state}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i;

    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // word load and store
    req(0, 2'b10, 0, 32'h1000_1010, 32'h0, 0, 32'h0000_0004); idle();
    req(1, 2'b10, 0, 32'h1000_1020, 32'h8899_AABB, 0, 32'h8899_AABB); idle();
    req(0, 2'b10, 0, 32'h1000_1020, 32'h0, 0, 32'h8899_AABB); idle();

    // sub-word read-modify-write and extension
    req(1, 2'b00, 0, 32'h1000_1022, 32'h0000_00FF, 0, 32'h88FF_AABB); idle();
    req(0, 2'b00, 0, 32'h1000_1022, 32'h0, 0, 32'hFFFF_FFFF); idle();
    req(0, 2'b00, 1, 32'h1000_1022, 32'h0, 0, 32'h0000_00FF); idle();
    req(0, 2'b01, 0, 32'h1000_1020, 32'h0, 0, 32'hFFFF_AABB); idle();
    req(0, 2'b01, 1, 32'h1000_1020, 32'h0, 0, 32'h0000_AABB); idle();
    req(0, 2'b00, 0, 32'h1000_1023, 32'h0, 0, 32'hFFFF_FF88); idle();
    req(0, 2'b01, 1, 32'h1000_1022, 32'h0, 0, 32'h0000_88FF); idle();
    req(0, 2'b10, 0, 32'h1000_1020, 32'h0, 0, 32'h88FF_AABB); idle();
    req(1, 2'b01, 0, 32'h1000_1016, 32'hABCD_1234, 0, 32'h1234_0005); idle();
    req(0, 2'b01, 0, 32'h1000_1016, 32'h0, 0, 32'h0000_1234); idle();
    req(0, 2'b00, 0, 32'h1000_1014, 32'h0, 0, 32'h0000_0005); idle();

    // range boundaries and errors
    req(0, 2'b10, 0, 32'h1000_13FC, 32'h0, 0, 32'h0000_00FF); idle();
    req(0, 2'b01, 0, 32'h1000_1021, 32'h0, 1, 32'h0); idle();
    req(0, 2'b10, 0, 32'h1000_1400, 32'h0, 1, 32'h0); idle();
    req(0, 2'b10, 0, 32'h1000_0FFC, 32'h0, 1, 32'h0); idle();
    req(0, 2'b11, 0, 32'h1000_1010, 32'h0, 1, 32'h0); idle();
    req(1, 2'b10, 0, 32'h1000_1022, 32'h1111_2222, 1, 32'h0); idle();

    // back-to-back: second request issued in the DONE cycle of the first
    req(0, 2'b10, 0, 32'h1000_1010, 32'h0, 0, 32'h0000_0004);
    req(1, 2'b00, 0, 32'h1000_1019, 32'h0000_005A, 0, 32'h0000_5A06);
    req(0, 2'b10, 0, 32'h1000_1018, 32'h0, 0, 32'h0000_5A06);
    idle();

    // reset in the middle of a word store
    ls_valid = 1'b1; ls_write = 1'b1; ls_size = 2'b10; ls_unsigned = 1'b0;
    ls_addr = 32'h1000_1030; ls_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 ls_valid = 1'b0;
    @(negedge clk);
    check("midwr_write", {31'b0, mem_write}, 32'h1);
    check("midwr_state", {29'b0, dbg_state}, 32'd3);
    rst_n = 1'b0;
    #1 check_all_zero("midwr_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    req(0, 2'b10, 0, 32'h1000_1010, 32'h0, 0, 32'h0000_0004); idle();
    idle();

    check("exp_q_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
